// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control path for a 16-entry (2**ADDR_W) single-clock FIFO.
// It drives an external memory_unit through wen/wrAddress and ren/rdAddress.
// It tracks the occupancy with a three-state FSM (EMPTY/PARTIAL/FULL) and a
// counter. rdValid flags the memory read data one cycle after an accepted pop.
// Optional build macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_ctrl #(
  parameter int DATA_W = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  output logic              wen,
  output logic              ren,
  output logic [ADDR_W-1:0] wrAddress,
  output logic [ADDR_W-1:0] rdAddress,
  output logic              rdValid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  // The data word never passes through this block; only sanity-check its width.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("fifo_ctrl: DATA_W must be at least 1");
  end

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              push_acc, pop_acc;

  // Acceptance is masked while reset_n is low so that no enable escapes during reset.
  assign push_acc = push & (state_q != S_FULL)  & reset_n;
  assign pop_acc  = pop  & (state_q != S_EMPTY) & reset_n;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_EMPTY;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (push_acc) state_d = S_PARTIAL;
      S_PARTIAL: begin
        if (push_acc && !pop_acc && count_q == CNT_LAST)    state_d = S_FULL;
        else if (pop_acc && !push_acc && count_q == CNT_ONE) state_d = S_EMPTY;
      end
      S_FULL: if (pop_acc) state_d = S_PARTIAL;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM outputs: flags come from the state, memory strobes from acceptance
  always_comb begin
    empty     = (state_q == S_EMPTY);
    full      = (state_q == S_FULL);
    wen       = push_acc;
    ren       = pop_acc;
    wrAddress = wr_ptr_q;
    rdAddress = rd_ptr_q;
  end

  // Pointer, occupancy and read-valid next-state values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop_acc;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and read-valid registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign count   = count_q;
  assign rdValid = rd_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: a request refused because the FIFO was full or empty
  always_comb begin
    overflow_d  = overflow_q  | (push & (state_q == S_FULL));
    underflow_d = underflow_q | (pop  & (state_q == S_EMPTY));
  end

  // Error flag registers, cleared only by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl (vector table plus fill/wrap/reset sequences).
module tb_fifo_ctrl;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic              wen, ren, rdValid, full, empty;
  logic [ADDR_W-1:0] wrAddress, rdAddress;
  logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow, underflow;
`endif

  int tests = 0;
  int failed = 0;

  fifo_ctrl #(.DATA_W(15), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
    .wen(wen), .ren(ren), .wrAddress(wrAddress), .rdAddress(rdAddress),
    .rdValid(rdValid), .full(full), .empty(empty), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       push, pop;
    logic       wen, ren;
    int         wra, rda;
    int         cnt;
    logic       emp, ful, rdv;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One cycle: drive at negedge, check strobes before the edge, optionally state after it.
  task automatic cycle(input logic p, input logic q, input logic ew, input logic er,
                       input int wa, input int ra);
    @(negedge clock);
    push = p;
    pop  = q;
    #1;
    check("wen", wen, ew);
    check("ren", ren, er);
    if (ew) check("wrAddress", wrAddress, wa);
    if (er) check("rdAddress", rdAddress, ra);
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            push pop wen ren wra rda cnt emp ful rdv
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 2, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 2, 0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 3, 0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 3, 0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 3, 1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4, 3, 1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 4, 0, 1'b1, 1'b0, 1'b1};

    // Reset state, with requests asserted to show they are masked.
    push = 1'b1;
    pop  = 1'b1;
    #12;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_wen", wen, 1'b0);
    check("rst_ren", ren, 1'b0);
    check("rst_wrAddress", wrAddress, 0);
    check("rst_rdAddress", rdAddress, 0);
    check("rst_count", count, 0);
    check("rst_rdValid", rdValid, 1'b0);
    @(posedge clock);
    #1;
    check("rst_hold_count", count, 0);
    do_reset();

    // Table: push x3, pop x3, idle, pop when empty, push+pop when empty/partial.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      push = vecs[i].push;
      pop  = vecs[i].pop;
      #1;
      check($sformatf("v%0d_wen", i), wen, vecs[i].wen);
      check($sformatf("v%0d_ren", i), ren, vecs[i].ren);
      check($sformatf("v%0d_wrAddress", i), wrAddress, vecs[i].wra);
      check($sformatf("v%0d_rdAddress", i), rdAddress, vecs[i].rda);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_count", i), count, vecs[i].cnt);
      check($sformatf("v%0d_empty", i), empty, vecs[i].emp);
      check($sformatf("v%0d_full", i), full, vecs[i].ful);
      check($sformatf("v%0d_rdValid", i), rdValid, vecs[i].rdv);
    end
`ifdef FIFO_ERR_FLAGS_EN
    check("underflow_set", underflow, 1'b1);
    check("overflow_clear", overflow, 1'b0);
`endif

    // Fill to 16, reject a 17th push, then pop once and run push+pop for 20 cycles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, i, 0);
      check("fill_count", count, i + 1);
      check("fill_full", full, (i == 15) ? 1'b1 : 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("ovf_count", count, 16);
    check("ovf_full", full, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow_set", overflow, 1'b1);
`endif
    // In FULL, push+pop accepts only the pop.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    check("fullpp_count", count, 15);
    check("fullpp_full", full, 1'b0);
    check("fullpp_rdValid", rdValid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1, i % 16, (i + 1) % 16);
      check("wrap_count", count, 15);
      check("wrap_full", full, 1'b0);
      check("wrap_empty", empty, 1'b0);
      check("wrap_rdValid", rdValid, 1'b1);
    end

    // Reset mid-operation at count 7 with a read pending.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, i, 0);
    check("mid_count7", count, 7);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 7, 0);
    check("mid_rdValid_pending", rdValid, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rdValid", rdValid, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_ren", ren, 1'b0);
    check("mid_rst_rdAddress", rdAddress, 0);
    check("mid_rst_wrAddress", wrAddress, 0);
    pop = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    check("post_rst_count", count, 1);
    check("post_rst_rdValid", rdValid, 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
    check("post_rst_overflow", overflow, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DATA_W, default 15: width of the data word carried through the FIFO.
REQ-002 Parameter ADDR_W, default 4: memory address width; depth is 2**ADDR_W (16).
REQ-003 Port clock, input, 1: single clock, rising-edge active.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port push, input, 1: write request from producer.
REQ-006 Port pop, input, 1: read request from consumer.
REQ-007 Port wen, output, 1: write enable to memory_unit.
REQ-008 Port ren, output, 1: read enable to memory_unit.
REQ-009 Port wrAddress, output, ADDR_W: memory write address.
REQ-010 Port rdAddress, output, ADDR_W: memory read address.
REQ-011 Port rdValid, output, 1: memory dataOut is valid for the pop accepted in the previous cycle.
REQ-012 Port full, output, 1: no free entry.
REQ-013 Port empty, output, 1: no stored entry.
REQ-014 Port count, output, ADDR_W+1: number of stored entries, 0..16.

Function
REQ-015 The FSM SHALL have three states, EMPTY, PARTIAL and FULL; empty is high only in EMPTY and full is high only in FULL, both decoded from the state register.
REQ-016 A push SHALL be accepted iff push=1 and state!=FULL.
REQ-017 A pop SHALL be accepted iff pop=1 and state!=EMPTY.
REQ-018 wen SHALL equal push-accepted combinationally, with wrAddress=wr_ptr in the same cycle.
REQ-019 ren SHALL equal pop-accepted combinationally, with rdAddress=rd_ptr in the same cycle.
REQ-020 wr_ptr SHALL increment modulo 16 at each clock edge where a push is accepted; rd_ptr SHALL do the same on an accepted pop; 15 wraps to 0.
REQ-021 count SHALL change by +1 on push only, by -1 on pop only, and SHALL be unchanged when both are accepted in the same cycle.
REQ-022 rdValid SHALL be a register set to 1 for exactly one cycle after each accepted pop (1-cycle read latency).
REQ-023 FSM transitions SHALL be as follows:
- EMPTY->PARTIAL on an accepted push.
- PARTIAL->FULL when count=15 and the cycle has a push only.
- PARTIAL->EMPTY when count=1 and the cycle has a pop only.
- FULL->PARTIAL on an accepted pop.
- Otherwise the FSM holds its state.
REQ-024 In EMPTY, push with pop SHALL accept the push only; there is no bypass, and rdValid stays low the next cycle.
REQ-025 In FULL, push with pop SHALL accept the pop only, so a write never targets the address being read.
REQ-026 In PARTIAL, push with pop SHALL accept both; the pointers advance and count is unchanged.
REQ-027 A rejected request SHALL have no side effect on the pointers, count, state, wen or ren.

Reset
REQ-028 While reset_n=0, the block SHALL asynchronously force state=EMPTY, wr_ptr=0, rd_ptr=0, count=0, rdValid=0.
REQ-029 While reset_n=0, the outputs SHALL be empty=1, full=0, wen=0, ren=0, wrAddress=0, rdAddress=0.
REQ-030 A reset asserted mid-operation SHALL discard all stored entries and cancel any pending rdValid.
REQ-031 Operation SHALL resume on the first rising clock edge after reset_n is released.

Configuration
REQ-032 When macro FIFO_ERR_FLAGS_EN is defined, the block SHALL add 1-bit outputs overflow and underflow.
- overflow sets on a push rejected due to FULL.
- underflow sets on a pop rejected due to EMPTY.
- Both flags are sticky until reset_n=0.
REQ-033 When FIFO_ERR_FLAGS_EN is undefined, those ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Scenario: reset, then 3 pushes -> wrAddress=0,1,2 with wen=1 each cycle; count=3; empty=0.
REQ-035 Scenario: 3 pops after REQ-034 -> rdAddress=0,1,2; rdValid high the cycle after each pop; count=0; empty=1.
REQ-036 Scenario: 16 pushes, then a 17th push -> full=1 after the 16th; 17th gives wen=0; count=16; overflow=1 if FIFO_ERR_FLAGS_EN.
REQ-037 Scenario: pop while empty -> ren=0 and rdValid=0 next cycle; underflow=1 if FIFO_ERR_FLAGS_EN.
REQ-038 Scenario: fill to 16, 1 pop, push+pop together for 20 cycles -> wrAddress/rdAddress wrap 15->0; count stays 15; state PARTIAL.
REQ-039 Scenario: reset_n low for 1 cycle at count=7 -> count=0, empty=1, pointers 0; the next push writes address 0.
